// File: rtl/trng_entropy_buffer.sv
// ---------------------------------------------------------------------------
// trng_entropy_buffer
//
// Runs the request/ready handshake with the TRNG word generator and
// health-screens every captured 32-bit word. Accepted words are stored in a
// first-word-fall-through FIFO. Crypto cores read that FIFO over a
// valid/ready interface. The block keeps the FIFO topped up on its own. A
// repetition failure latches a sticky health_fail, flushes the FIFO and
// stops all further requests until software pulses fail_clear.
//
// Handshake semantics: a transfer on the consumer side happens at the rising
// edge where rnd_valid && rnd_ready; rnd_data holds the head word whenever
// rnd_valid is 1, and rnd_ready while rnd_valid=0 has no effect. On the TRNG
// side a word is taken at the first edge where trng_ready=1 while requested.
//
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   trng_request    registered request to the TRNG
//   trng_ready      TRNG word-ready flag
//   trng_data       TRNG word, valid while trng_ready=1
//   rnd_valid       FIFO not empty
//   rnd_data        FIFO head word
//   rnd_ready       consumer pop
//   fill_level      FIFO occupancy
//   health_fail     sticky repetition-test failure
//   fail_clear      one-cycle pulse that clears health_fail
//   discard_count   saturating count of rejected words
// ---------------------------------------------------------------------------
module trng_entropy_buffer #(
    parameter int DEPTH     = 8,
    parameter int REP_LIMIT = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    output logic                     trng_request,
    input  logic                     trng_ready,
    input  logic [31:0]              trng_data,
    output logic                     rnd_valid,
    output logic [31:0]              rnd_data,
    input  logic                     rnd_ready,
    output logic [$clog2(DEPTH):0]   fill_level,
    output logic                     health_fail,
    input  logic                     fail_clear,
    output logic [15:0]              discard_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DROP = 2'd2
    } state_t;

    state_t         state;
    state_t         state_nx;
    logic           request_nx;

    logic [31:0]    mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;

    logic [31:0]    prev_word;
    logic           prev_valid;
    logic [3:0]     rep_cnt;

    logic           capture;
    logic           word_stuck;
    logic           word_rep;
    logic [4:0]     rep_next;
    logic           push;
    logic           pop;
    logic           discard;
    logic           fail;

    // Word evaluation, in priority order: stuck pattern, repeat, accept.
    assign capture    = (state == REQ) && trng_ready;
    assign word_stuck = (trng_data == 32'h0000_0000) || (trng_data == 32'hFFFF_FFFF);
    assign word_rep   = prev_valid && (trng_data == prev_word);
    assign rep_next   = {1'b0, rep_cnt} + 5'd1;
    assign push       = capture && !word_stuck && !word_rep;
    assign discard    = capture && (word_stuck || word_rep);
    assign fail       = capture && !word_stuck && word_rep && (rep_next == 5'(REP_LIMIT));
    assign pop        = rnd_ready && rnd_valid;

    assign rnd_valid  = (fill_level != '0);
    assign rnd_data   = mem[rd_ptr];

    // Request FSM next-state and registered-request logic.
    always_comb begin
        state_nx   = state;
        request_nx = 1'b0;
        case (state)
            IDLE: begin
                if ((fill_level < LW'(DEPTH)) && !health_fail) begin
                    state_nx   = REQ;
                    request_nx = 1'b1;
                end
            end
            REQ: begin
                if (trng_ready) begin
                    state_nx = DROP;
                end else begin
                    request_nx = 1'b1;
                end
            end
            DROP: begin
                // Request is low here, so the TRNG drops ready and restarts.
                if (!trng_ready) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            trng_request  <= 1'b0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            fill_level    <= '0;
            health_fail   <= 1'b0;
            discard_count <= '0;
            prev_word     <= '0;
            prev_valid    <= 1'b0;
            rep_cnt       <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            state        <= state_nx;
            trng_request <= request_nx;

            if (discard && (discard_count != 16'hFFFF)) begin
                discard_count <= discard_count + 16'd1;
            end

            // Health-test history. A clear wipes the history and a failure
            // invalidates it, so both override the update from this word.
            if (capture && !word_stuck && word_rep) begin
                rep_cnt <= rep_next[3:0];
            end else if (push) begin
                prev_word  <= trng_data;
                prev_valid <= 1'b1;
                rep_cnt    <= 4'd1;
            end
            if (fail_clear) begin
                rep_cnt    <= '0;
                prev_valid <= 1'b0;
            end
            if (fail) begin
                prev_valid <= 1'b0;
            end

            // A failure on the same edge as a clear keeps the flag set.
            if (fail) begin
                health_fail <= 1'b1;
            end else if (fail_clear) begin
                health_fail <= 1'b0;
            end

            // FIFO. A flush beats any same-edge pop. No push can happen on
            // a failure edge, because the failing word is always discarded.
            if (fail) begin
                wr_ptr     <= '0;
                rd_ptr     <= '0;
                fill_level <= '0;
            end else begin
                if (push) begin
                    mem[wr_ptr] <= trng_data;
                    wr_ptr      <= wr_ptr + AW'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + AW'(1);
                end
                case ({push, pop})
                    2'b10:   fill_level <= fill_level + LW'(1);
                    2'b01:   fill_level <= fill_level - LW'(1);
                    default: fill_level <= fill_level;
                endcase
            end
        end
    end

endmodule
